// File: rtl/jk_reg_bank.sv
`default_nettype none
// ============================================================================
// Module     : jk_reg_bank
// Description: WIDTH-bit register bank built from per-bit JK cells, with
//              runtime mode select (JK / D / T / up-down COUNT), clock
//              enable, synchronous clear, change/wrap flags and a saturating
//              change-event counter.
//              Optional macro JK_REG_BANK_PARITY_EN adds a registered
//              even-parity output that always equals ^out.
// Revision   : 1.0 - initial release
// ============================================================================
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sclr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_n,
  output logic             changed,
  output logic             wrap,
  output logic [CNT_W-1:0] tog_cnt
`ifdef JK_REG_BANK_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [1:0]       C_MODE_JK    = 2'b00;
  localparam logic [1:0]       C_MODE_D     = 2'b01;
  localparam logic [1:0]       C_MODE_T     = 2'b10;
  localparam logic [1:0]       C_MODE_COUNT = 2'b11;

  localparam logic [WIDTH-1:0] C_ONES    = '1;
  localparam logic [WIDTH-1:0] C_ZERO    = '0;
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_changed;
  logic             r_wrap;
  logic [CNT_W-1:0] r_tog_cnt;

  logic [WIDTH-1:0] w_jk;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_cnt;
  logic             w_up;
  logic             w_dn;
  logic             w_cnt_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;
  logic             w_changed_next;

  // Candidate next values for each mode, computed in parallel per bit.
  // JK cell equation: Q+ = J & ~Q | ~K & Q (hold / set / clear / toggle).
  always_comb begin
    w_jk       = (j & ~r_out) | (~k & r_out);
    w_t        = r_out ^ j;
    w_up       = j[0] & ~k[0];
    w_dn       = ~j[0] & k[0];
    w_cnt      = r_out;
    w_cnt_wrap = 1'b0;
    if (w_up) begin
      w_cnt      = r_out + C_ONE;
      w_cnt_wrap = (r_out == C_ONES);
    end else if (w_dn) begin
      w_cnt      = r_out - C_ONE;
      w_cnt_wrap = (r_out == C_ZERO);
    end
  end

  // Priority select: sclr beats a disabled clock, which beats the mode action.
  always_comb begin
    w_next      = r_out;
    w_wrap_next = 1'b0;
    if (sclr) begin
      w_next = RESET_VAL;
    end else if (en) begin
      unique case (mode)
        C_MODE_JK: w_next = w_jk;
        C_MODE_D:  w_next = j;
        C_MODE_T:  w_next = w_t;
        C_MODE_COUNT: begin
          w_next      = w_cnt;
          w_wrap_next = w_cnt_wrap;
        end
        default:   w_next = r_out;
      endcase
    end
    w_changed_next = (w_next != r_out);
  end

  // State register, flags and saturating change counter (sclr leaves the
  // counter alone; only reset clears it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= RESET_VAL;
      r_changed <= 1'b0;
      r_wrap    <= 1'b0;
      r_tog_cnt <= '0;
    end else begin
      r_out     <= w_next;
      r_changed <= w_changed_next;
      r_wrap    <= w_wrap_next;
      if (w_changed_next && (r_tog_cnt != C_CNT_MAX)) begin
        r_tog_cnt <= r_tog_cnt + C_CNT_ONE;
      end
    end
  end

`ifdef JK_REG_BANK_PARITY_EN
  logic r_parity;

  // Parity is registered from the same next value as out so it never lags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= ^RESET_VAL;
    end else begin
      r_parity <= ^w_next;
    end
  end

  assign parity = r_parity;
`endif

  assign out     = r_out;
  assign out_n   = ~r_out;
  assign changed = r_changed;
  assign wrap    = r_wrap;
  assign tog_cnt = r_tog_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jk_reg_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_jk_reg_bank
// Description: Self-checking bench for jk_reg_bank. A second instance with a
//              2-bit change counter exercises counter saturation.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sclr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;

  logic [7:0] out, out_n, out2, out_n2;
  logic       changed, wrap, changed2, wrap2;
  logic [7:0] tog_cnt;
  logic [1:0] tog_cnt2;
`ifdef JK_REG_BANK_PARITY_EN
  logic       parity, parity2;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_out;
  logic       m_changed;
  logic       m_wrap;
  int         m_changes;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .j(j), .k(k),
    .out(out), .out_n(out_n), .changed(changed), .wrap(wrap), .tog_cnt(tog_cnt)
`ifdef JK_REG_BANK_PARITY_EN
    , .parity(parity)
`endif
  );

  jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .sclr(sclr), .mode(mode), .j(j), .k(k),
    .out(out2), .out_n(out_n2), .changed(changed2), .wrap(wrap2), .tog_cnt(tog_cnt2)
`ifdef JK_REG_BANK_PARITY_EN
    , .parity(parity2)
`endif
  );

  function automatic logic [7:0] m8();
    return (m_changes > 255) ? 8'd255 : 8'(m_changes);
  endfunction

  function automatic logic [1:0] m2();
    return (m_changes > 3) ? 2'd3 : 2'(m_changes);
  endfunction

  task automatic model_reset();
    m_out = 8'h00; m_changed = 1'b0; m_wrap = 1'b0; m_changes = 0;
  endtask

  // Behavioural model of one rising edge, from the current inputs.
  task automatic model_edge();
    logic [7:0] nxt;
    int v;
    nxt = m_out;
    m_wrap = 1'b0;
    if (sclr) nxt = 8'h00;
    else if (en) begin
      case (mode)
        2'b00: for (int i = 0; i < 8; i++) begin
          if (j[i] && k[i])       nxt[i] = ~m_out[i];
          else if (j[i])          nxt[i] = 1'b1;
          else if (k[i])          nxt[i] = 1'b0;
        end
        2'b01: nxt = j;
        2'b10: for (int i = 0; i < 8; i++) if (j[i]) nxt[i] = ~m_out[i];
        default: begin
          v = int'(m_out);
          if (j[0] && !k[0]) v = v + 1;
          else if (!j[0] && k[0]) v = v - 1;
          if (v > 255) begin v = 0;   m_wrap = 1'b1; end
          if (v < 0)   begin v = 255; m_wrap = 1'b1; end
          nxt = 8'(v);
        end
      endcase
    end
    m_changed = (nxt != m_out);
    if (m_changed) m_changes++;
    m_out = nxt;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; sclr = 1'b0;
    #100;
    model_reset();
    checks++;
    if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {8'h00, 8'hFF, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_state got=%h required=%h", {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
               {8'h00, 8'hFF, 1'b0, 1'b0, 8'd0, 2'd0});
    end
`ifdef JK_REG_BANK_PARITY_EN
    checks++;
    if (parity !== 1'b0) begin failures++; $display("FAIL reset_parity got=%b required=0", parity); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_jk();
    logic [7:0] tj [3] = '{8'hFF, 8'hFF, 8'h00};
    logic [7:0] tk [3] = '{8'h00, 8'hFF, 8'h00};
    logic [7:0] eo [3] = '{8'hFF, 8'h00, 8'h00};
    mode = 2'b00; en = 1'b1; sclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      j = tj[i]; k = tk[i];
      tick();
      checks++;
      if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
        failures++;
        $display("FAIL jk_step%0d got=%h required=%h", i, {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
                 {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
      end
      checks++;
      if (out !== eo[i]) begin failures++; $display("FAIL jk_const%0d out=%h required=%h", i, out, eo[i]); end
    end
    checks++;
    if (changed !== 1'b0 || tog_cnt !== 8'd2) begin
      failures++;
      $display("FAIL jk_hold changed=%b tog_cnt=%0d required 0/2", changed, tog_cnt);
    end
  endtask

  task automatic test_mixed();
    logic [1:0] tm [3] = '{2'b01, 2'b00, 2'b00};
    logic [7:0] tj [3] = '{8'h0F, 8'hA5, 8'h81};
    logic [7:0] tk [3] = '{8'h00, 8'h5A, 8'h81};
    logic [7:0] eo [3] = '{8'h0F, 8'hA5, 8'h24};
    en = 1'b1; sclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = tm[i]; j = tj[i]; k = tk[i];
      tick();
      checks++;
      if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
        failures++;
        $display("FAIL mixed_step%0d got=%h required=%h", i, {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
                 {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
      end
      checks++;
      if (out !== eo[i]) begin failures++; $display("FAIL mixed_const%0d out=%h required=%h", i, out, eo[i]); end
    end
  endtask

  task automatic test_d_t_en();
    logic [1:0] tm [3] = '{2'b01, 2'b10, 2'b01};
    logic [7:0] tj [3] = '{8'h3C, 8'h0F, 8'hFF};
    logic       te [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] eo [3] = '{8'h3C, 8'h33, 8'h33};
    sclr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = tm[i]; j = tj[i]; k = 8'($urandom); en = te[i];
      tick();
      checks++;
      if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
        failures++;
        $display("FAIL dten_step%0d got=%h required=%h", i, {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
                 {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
      end
      checks++;
      if (out !== eo[i]) begin failures++; $display("FAIL dten_const%0d out=%h required=%h", i, out, eo[i]); end
    end
    checks++;
    if (changed !== 1'b0) begin failures++; $display("FAIL en_low_changed got=%b required=0", changed); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] tm [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [7:0] tj [6] = '{8'hFE, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
    logic [7:0] tk [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    logic [7:0] eo [6] = '{8'hFE, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    logic       ew [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    en = 1'b1; sclr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mode = tm[i];
      // Upper bits are noise in COUNT mode and must be ignored.
      j = (i == 0) ? tj[i] : {7'($urandom), tj[i][0]};
      k = (i == 0) ? tk[i] : {7'($urandom), tk[i][0]};
      tick();
      checks++;
      if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
        failures++;
        $display("FAIL count_step%0d got=%h required=%h", i, {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
                 {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
      end
      checks++;
      if ({out, wrap} !== {eo[i], ew[i]}) begin
        failures++;
        $display("FAIL count_const%0d out/wrap=%h/%b required=%h/%b", i, out, wrap, eo[i], ew[i]);
      end
    end
  endtask

  task automatic test_sclr_async();
    // Load a nonzero value, then sclr with the clock disabled.
    mode = 2'b01; en = 1'b1; sclr = 1'b0; j = 8'hA7; k = 8'h00;
    tick();
    en = 1'b0; sclr = 1'b1; mode = 2'($urandom); j = 8'($urandom); k = 8'($urandom);
    tick();
    checks++;
    if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
      failures++;
      $display("FAIL sclr got=%h required=%h", {out, out_n, changed, wrap, tog_cnt, tog_cnt2},
               {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
    end
    checks++;
    if (out !== 8'h00 || changed !== 1'b1 || tog_cnt === 8'd0) begin
      failures++;
      $display("FAIL sclr_const out=%h changed=%b tog_cnt=%0d required 00/1/nonzero", out, changed, tog_cnt);
    end
    // Count up, then hit reset between edges.
    sclr = 1'b0; en = 1'b1; mode = 2'b11; j = 8'h01; k = 8'h00;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({out, changed, wrap, tog_cnt, tog_cnt2} !== {8'h00, 1'b0, 1'b0, 8'd0, 2'd0}) begin
      failures++;
      $display("FAIL async_reset got=%h required=%h", {out, changed, wrap, tog_cnt, tog_cnt2},
               {8'h00, 1'b0, 1'b0, 8'd0, 2'd0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    checks++;
    if ({out, changed, tog_cnt} !== {8'h01, 1'b1, 8'd1}) begin
      failures++;
      $display("FAIL post_reset_count got=%h required=%h", {out, changed, tog_cnt}, {8'h01, 1'b1, 8'd1});
    end
  endtask

  task automatic test_saturation();
    logic [1:0] ec [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
    mode = 2'b10; en = 1'b1; sclr = 1'b0; j = 8'hFF; k = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({tog_cnt2, tog_cnt} !== {ec[i], 8'(i + 1)} || tog_cnt2 !== m2()) begin
        failures++;
        $display("FAIL saturation%0d tog_cnt2/tog_cnt=%0d/%0d required=%0d/%0d", i, tog_cnt2, tog_cnt, ec[i], i + 1);
      end
    end
  endtask

`ifdef JK_REG_BANK_PARITY_EN
  task automatic test_parity();
    mode = 2'b01; en = 1'b1; sclr = 1'b0; j = 8'h07; k = 8'h00;
    tick();
    checks++;
    if (parity !== 1'b1 || parity2 !== 1'b1) begin
      failures++;
      $display("FAIL parity_07 got=%b/%b required=1", parity, parity2);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] picks [4] = '{8'hFF, 8'h00, 8'hFE, 8'h01};
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(9) == 0) begin
        mode = 2'b01; en = 1'b1; sclr = 1'b0; j = picks[$urandom_range(3)]; k = 8'($urandom);
      end else begin
        mode = 2'($urandom); j = 8'($urandom); k = 8'($urandom);
        en = ($urandom_range(7) != 0);
        sclr = ($urandom_range(15) == 0);
      end
      tick();
      checks++;
      if ({out, out_n, changed, wrap, tog_cnt, tog_cnt2} !== {m_out, ~m_out, m_changed, m_wrap, m8(), m2()}) begin
        failures++;
        $display("FAIL random%0d mode=%b j=%h k=%h en=%b sclr=%b got=%h required=%h", n, mode, j, k, en, sclr,
                 {out, out_n, changed, wrap, tog_cnt, tog_cnt2}, {m_out, ~m_out, m_changed, m_wrap, m8(), m2()});
      end
`ifdef JK_REG_BANK_PARITY_EN
      checks++;
      if (parity !== ^m_out) begin
        failures++;
        $display("FAIL random_parity%0d got=%b required=%b", n, parity, ^m_out);
      end
`endif
    end
    sclr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jk();
    test_mixed();
    test_d_t_en();
    test_count_wrap();
    test_sclr_async();
    test_saturation();
`ifdef JK_REG_BANK_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
